// File: rtl/prf_free_list_pkg.sv
// Shared rename/backend definitions for the physical register free list.
// Holds the register-file geometry and the register/pointer types used by
// prf_free_list and anything that talks to it.
package prf_free_list_pkg;

  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;
  localparam int PREG_W   = $clog2(NUM_PREG);
  localparam int FL_DEPTH = NUM_PREG - NUM_AREG;
  // One extra bit beyond the index: the wrap bit separates full from empty.
  localparam int FL_PTR_W = $clog2(FL_DEPTH) + 1;

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/prf_free_list.sv
// Physical register free list.
// Circular FIFO of free physical registers with three pointers:
//   head     - speculative allocation point (rename side)
//   cmt_head - allocation point as seen by retired instructions
//   tail     - reclaim point (commit side)
// A flush rolls head back to cmt_head in one cycle, returning every register
// taken by squashed instructions. P0 is never in the list.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   alloc_req      rename wants one register this cycle
//   alloc_ready    list non-empty, a request will be granted
//   alloc_pd       register granted (head entry, same cycle)
//   commit_valid   retiring instruction frees its previous mapping
//   commit_pd_old  previous mapping to reclaim
//   flush          squash speculative allocations
//   free_count     number of free registers (tail - head)
module prf_free_list
  import prf_free_list_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    alloc_req,
  output logic    alloc_ready,
  output preg_t   alloc_pd,
  input  logic    commit_valid,
  input  preg_t   commit_pd_old,
  input  logic    flush,
  output fl_ptr_t free_count
);

  localparam int      IDX_W   = FL_PTR_W - 1;
  localparam fl_ptr_t PTR_ONE = fl_ptr_t'(1);

  preg_t   fifo [FL_DEPTH];
  fl_ptr_t head;
  fl_ptr_t cmt_head;
  fl_ptr_t tail;

  logic    alloc_fire;
  fl_ptr_t cmt_head_next;

  // Empty when the pointers match exactly; the wrap bit makes
  // tail - head == FL_DEPTH the full case.
  assign alloc_ready   = (tail != head);
  assign alloc_pd      = fifo[head[IDX_W-1:0]];
  assign free_count    = tail - head;
  assign alloc_fire    = alloc_req & alloc_ready & ~flush;
  // Flush restores to the commit point including this cycle's retirement.
  assign cmt_head_next = cmt_head + fl_ptr_t'(commit_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      cmt_head <= '0;
      tail     <= fl_ptr_t'(FL_DEPTH);
      for (int i = 0; i < FL_DEPTH; i++) begin
        fifo[i] <= preg_t'(NUM_AREG + i);
      end
    end else begin
      // alloc_ready is judged on the pre-commit tail, so a register reclaimed
      // this cycle is only allocatable from the next cycle on.
      if (commit_valid) begin
        fifo[tail[IDX_W-1:0]] <= commit_pd_old;
        tail                  <= tail + PTR_ONE;
      end
      cmt_head <= cmt_head_next;
      if (flush) begin
        head <= cmt_head_next;
      end else if (alloc_fire) begin
        head <= head + PTR_ONE;
      end
    end
  end

  a_tail_cmt_gap: assert property (@(posedge clk) disable iff (rst)
    fl_ptr_t'(tail - cmt_head) == fl_ptr_t'(FL_DEPTH));

  a_free_count_range: assert property (@(posedge clk) disable iff (rst)
    free_count <= fl_ptr_t'(FL_DEPTH));

  a_no_p0_reclaim: assert property (@(posedge clk) disable iff (rst)
    commit_valid |-> (commit_pd_old != '0));

  a_commit_has_alloc: assert property (@(posedge clk) disable iff (rst)
    commit_valid |-> (cmt_head != head));

endmodule
